// File: rtl/fetch_if.sv
// fetch_if: fetch-stage signal bundle.
//   master (fetch unit): drives pc_addr, ir, ir_pc, ir_valid, halted;
//                        receives mem_instr, stall, branch_taken, branch_target.
//   slave  (memory/decoder side): the mirror image.
interface fetch_if #(
  parameter int addWidth  = 6,
  parameter int dataWidth = 16
);
  logic [addWidth-1:0]  pc_addr;
  logic [dataWidth-1:0] mem_instr;
  logic                 stall;
  logic                 branch_taken;
  logic [addWidth-1:0]  branch_target;
  logic [dataWidth-1:0] ir;
  logic [addWidth-1:0]  ir_pc;
  logic                 ir_valid;
  logic                 halted;

  modport master (
    output pc_addr, ir, ir_pc, ir_valid, halted,
    input  mem_instr, stall, branch_taken, branch_target
  );

  modport slave (
    input  pc_addr, ir, ir_pc, ir_valid, halted,
    output mem_instr, stall, branch_taken, branch_target
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the PC, drives the instruction
// memory address, captures the combinational read data into the instruction
// register and flags it valid for the decoder. Supports stall, branch
// redirect with a one-slot flush, and stopping on a halt opcode.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - fetch_if.master: pc_addr, mem_instr, stall, branch_taken,
//          branch_target, ir, ir_pc, ir_valid, halted
module fetch_unit #(
  parameter int         addWidth    = 6,
  parameter int         dataWidth   = 16,
  parameter logic [3:0] HALT_OPCODE = 4'hF
) (
  input  logic clk,
  input  logic rst,
  fetch_if.master bus
);

  typedef enum logic {RUN, HALT} state_t;

  state_t               state_q, state_d;
  logic [addWidth-1:0]  pc_p0, pc_d;
  logic [dataWidth-1:0] ir_p1, ir_d;
  logic [addWidth-1:0]  ir_pc_p1, ir_pc_d;
  logic                 vld_p1, vld_d;
  logic                 is_halt_op;

  assign is_halt_op = (bus.mem_instr[dataWidth-1 -: 4] == HALT_OPCODE);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_p0;
    ir_d    = ir_p1;
    ir_pc_d = ir_pc_p1;
    vld_d   = vld_p1;
    case (state_q)
      RUN: begin
        if (bus.branch_taken) begin
          // Redirect flushes the slot being fetched; branch beats stall.
          pc_d  = bus.branch_target;
          vld_d = 1'b0;
        end else if (!bus.stall) begin
          ir_d    = bus.mem_instr;
          ir_pc_d = pc_p0;
          vld_d   = 1'b1;
          if (is_halt_op) begin
            state_d = HALT;
          end else begin
            pc_d = pc_p0 + addWidth'(1);
          end
        end
      end
      HALT: begin
        // PC frozen, branches ignored; the halt instruction is retired
        // on the first unstalled edge.
        if (!bus.stall) begin
          vld_d = 1'b0;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Stage p0: program counter / FSM state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_p0   <= '0;
    end else begin
      state_q <= state_d;
      pc_p0   <= pc_d;
    end
  end

  // Stage p1: instruction register
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_p1    <= '0;
      ir_pc_p1 <= '0;
      vld_p1   <= 1'b0;
    end else begin
      ir_p1    <= ir_d;
      ir_pc_p1 <= ir_pc_d;
      vld_p1   <= vld_d;
    end
  end

  assign bus.pc_addr  = pc_p0;
  assign bus.ir       = ir_p1;
  assign bus.ir_pc    = ir_pc_p1;
  assign bus.ir_valid = vld_p1;
  assign bus.halted   = (state_q == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed test of fetch_unit with a behavioural instruction
// memory; expected values are hand-computed per step.
module tb_fetch_unit;
  localparam int AW = 6;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  fetch_if #(.addWidth(AW), .dataWidth(DW)) bus ();

  fetch_unit #(.addWidth(AW), .dataWidth(DW), .HALT_OPCODE(4'hF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_instr = mem[bus.pc_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // advance one edge, settle after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_all(input string tag, input logic [AW-1:0] pc,
                            input logic [DW-1:0] ir, input logic [AW-1:0] irpc,
                            input logic vld, input logic hlt);
    check({tag, ".pc"},     32'(bus.pc_addr),  32'(pc));
    check({tag, ".ir"},     32'(bus.ir),       32'(ir));
    check({tag, ".ir_pc"},  32'(bus.ir_pc),    32'(irpc));
    check({tag, ".vld"},    32'(bus.ir_valid), 32'(vld));
    check({tag, ".halted"}, 32'(bus.halted),   32'(hlt));
  endtask

  initial begin
    for (int i = 0; i < (1<<AW); i++) mem[i] = 16'h3000 | 16'(i);
    mem[0]  = 16'h1001;
    mem[1]  = 16'h1002;
    mem[2]  = 16'h1003;
    mem[3]  = 16'h1004;
    mem[5]  = 16'hF000;
    mem[63] = 16'h2000;

    rst = 1'b1;
    bus.stall = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_target = '0;
    step();
    step();
    expect_all("reset", 6'd0, 16'h0000, 6'd0, 1'b0, 1'b0);

    // sequential fetch
    rst = 1'b0;
    step();
    expect_all("seq0", 6'd1, 16'h1001, 6'd0, 1'b1, 1'b0);
    step();
    expect_all("seq1", 6'd2, 16'h1002, 6'd1, 1'b1, 1'b0);

    // stall holds everything for 3 cycles
    bus.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      expect_all("stall", 6'd2, 16'h1002, 6'd1, 1'b1, 1'b0);
    end
    bus.stall = 1'b0;
    step();
    expect_all("unstall", 6'd3, 16'h1003, 6'd2, 1'b1, 1'b0);

    // reset mid-run at PC=3
    rst = 1'b1;
    step();
    expect_all("rst_run", 6'd0, 16'h0000, 6'd0, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    expect_all("restart", 6'd1, 16'h1001, 6'd0, 1'b1, 1'b0);

    // branch to 40
    bus.branch_taken = 1'b1;
    bus.branch_target = 6'd40;
    step();
    expect_all("br", 6'd40, 16'h1001, 6'd0, 1'b0, 1'b0);
    bus.branch_taken = 1'b0;
    step();
    expect_all("br_fetch", 6'd41, 16'h3028, 6'd40, 1'b1, 1'b0);

    // branch wins over stall
    bus.branch_taken = 1'b1;
    bus.stall = 1'b1;
    step();
    expect_all("br_stall", 6'd40, 16'h3028, 6'd40, 1'b0, 1'b0);
    bus.branch_taken = 1'b0;
    bus.stall = 1'b0;
    step();
    expect_all("br_stall_fetch", 6'd41, 16'h3028, 6'd40, 1'b1, 1'b0);

    // PC wrap 63 -> 0
    bus.branch_taken = 1'b1;
    bus.branch_target = 6'd63;
    step();
    bus.branch_taken = 1'b0;
    step();
    expect_all("wrap", 6'd0, 16'h2000, 6'd63, 1'b1, 1'b0);
    step();
    expect_all("wrap_next", 6'd1, 16'h1001, 6'd0, 1'b1, 1'b0);

    // halt opcode presented during stall is not detected
    bus.branch_taken = 1'b1;
    bus.branch_target = 6'd5;
    step();
    bus.branch_taken = 1'b0;
    bus.stall = 1'b1;
    step();
    expect_all("halt_stalled", 6'd5, 16'h1001, 6'd0, 1'b0, 1'b0);
    bus.stall = 1'b0;
    step();
    expect_all("halt", 6'd5, 16'hF000, 6'd5, 1'b1, 1'b1);
    bus.stall = 1'b1;
    step();
    expect_all("halt_hold", 6'd5, 16'hF000, 6'd5, 1'b1, 1'b1);
    bus.stall = 1'b0;
    step();
    expect_all("halt_retire", 6'd5, 16'hF000, 6'd5, 1'b0, 1'b1);
    bus.branch_taken = 1'b1;
    bus.branch_target = 6'd40;
    step();
    bus.branch_taken = 1'b0;
    expect_all("halt_br", 6'd5, 16'hF000, 6'd5, 1'b0, 1'b1);

    // reset while halted
    rst = 1'b1;
    step();
    expect_all("rst_halt", 6'd0, 16'h0000, 6'd0, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    expect_all("restart2", 6'd1, 16'h1001, 6'd0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
